// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: streams 24-bit GRB pixels (MSB first) as a WS2812 bit train, one frame of N_LEDS pixels then a latch gap.
// clk_200/restn: clock, async active-low reset; pix_data/pix_valid/pix_ready: pixel handshake;
// ws: registered serial line; busy: not IDLE; frame_done: pulse on last latch cycle; underrun: sticky truncated-frame flag.
module ws2812_chain_driver #(
  parameter int N_LEDS    = 123,
  parameter int T0H_CYC   = 80,
  parameter int T1H_CYC   = 160,
  parameter int BIT_CYC   = 250,
  parameter int LATCH_CYC = 56000
) (
  input  logic        clk_200,
  input  logic        restn,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        ws,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);
  localparam int BW = $clog2(BIT_CYC);
  localparam int PW = N_LEDS > 1 ? $clog2(N_LEDS) : 1;
  localparam int LW = LATCH_CYC > 1 ? $clog2(LATCH_CYC) : 1;
  localparam logic [BW-1:0] T0 = BW'(T0H_CYC);
  localparam logic [BW-1:0] T1 = BW'(T1H_CYC);
  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
  state_t state, state_n;
  logic [23:0] sr, sr_n, hr, hr_n;
  logic hold, hold_n, live, ws_n, uf_n, acc, bit_end, pix_end, last_pix, latch_end;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [4:0] bidx, bidx_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  // live keeps pix_ready low until the first edge after reset release
  assign pix_ready  = live && !hold && state != LATCH;
  assign acc        = pix_valid && pix_ready;
  assign busy       = state != IDLE;
  assign bit_end    = bcnt == BW'(BIT_CYC - 1);
  assign pix_end    = bit_end && bidx == 5'd23;
  assign last_pix   = pcnt == PW'(N_LEDS - 1);
  assign latch_end  = lcnt == LW'(LATCH_CYC - 1);
  assign frame_done = state == LATCH && latch_end;
  // bcnt and bidx are already zero whenever SEND is entered, so entry paths leave them alone
  always_comb begin
    state_n = state;
    sr_n    = sr;
    hr_n    = hr;
    hold_n  = hold;
    bcnt_n  = bcnt;
    bidx_n  = bidx;
    pcnt_n  = pcnt;
    lcnt_n  = lcnt;
    uf_n    = underrun;
    if (acc && state == IDLE) begin
      sr_n    = pix_data;
      state_n = SEND;
      uf_n    = 1'b0;
    end
    if (acc && state == SEND) begin
      hr_n   = pix_data;
      hold_n = 1'b1;
    end
    if (state == SEND) begin
      bcnt_n = bit_end ? '0 : bcnt + 1'b1;
      if (bit_end && !pix_end) begin
        sr_n   = {sr[22:0], 1'b0};
        bidx_n = bidx + 5'd1;
      end
      if (pix_end) begin
        bidx_n = '0;
        if (!last_pix && hold) begin
          sr_n   = hr;
          hold_n = 1'b0;
          pcnt_n = pcnt + 1'b1;
        end else begin
          state_n = LATCH;
          lcnt_n  = '0;
          uf_n    = underrun | !last_pix;
        end
      end
    end
    if (state == LATCH) begin
      lcnt_n = latch_end ? '0 : lcnt + 1'b1;
      if (latch_end) begin
        pcnt_n  = '0;
        state_n = hold ? SEND : IDLE;
        if (hold) begin
          sr_n   = hr;
          hold_n = 1'b0;
          uf_n   = 1'b0;
        end
      end
    end
    // ws is computed from next-cycle state so the line itself is a flop
    ws_n = state_n == SEND && bcnt_n < (sr_n[23] ? T1 : T0);
  end
  always_ff @(posedge clk_200 or negedge restn) begin
    if (!restn) begin
      state    <= IDLE;
      sr       <= '0;
      hr       <= '0;
      hold     <= 1'b0;
      live     <= 1'b0;
      ws       <= 1'b0;
      underrun <= 1'b0;
      bcnt     <= '0;
      bidx     <= '0;
      pcnt     <= '0;
      lcnt     <= '0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      hr       <= hr_n;
      hold     <= hold_n;
      live     <= 1'b1;
      ws       <= ws_n;
      underrun <= uf_n;
      bcnt     <= bcnt_n;
      bidx     <= bidx_n;
      pcnt     <= pcnt_n;
      lcnt     <= lcnt_n;
    end
  end
endmodule
